// File: rtl/add_accum_pkg.sv
// Shared opcode definitions for the add/subtract/accumulate unit.
package add_accum_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } op_e;

endpackage

// File: rtl/add_accum_alu.sv
// Combinational datapath: computes result, overflow/borrow flag and the
// accumulator value that a beat in S1 would leave behind once it reaches S2.
module add_accum_alu
    import add_accum_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  op_e                  op,
    input  logic                 sat,
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 flag,
    output logic [ACC_WIDTH-1:0] acc_next
);

    localparam int AW1 = ACC_WIDTH + 1;

    logic [WIDTH+1:0]   add_sum_s;
    logic [WIDTH:0]     sub_diff_s;
    logic [ACC_WIDTH:0] acc_sum_s;

    // Widened sums so carry/borrow fall out as the top bit.
    always_comb begin
        add_sum_s  = {2'b00, a} + {2'b00, b};
        sub_diff_s = {1'b0, a} - {1'b0, b};
        acc_sum_s  = {1'b0, acc} + AW1'(a) + AW1'(b);
    end

    always_comb begin
        result   = {ACC_WIDTH{1'b0}};
        flag     = 1'b0;
        acc_next = acc;
        case (op)
            OP_ADD: begin
                result = ACC_WIDTH'(add_sum_s[WIDTH:0]);
                flag   = add_sum_s[WIDTH+1];
            end
            OP_SUB: begin
                flag = sub_diff_s[WIDTH];
                if (sub_diff_s[WIDTH] && sat) begin
                    result = {ACC_WIDTH{1'b0}};
                end else begin
                    result = ACC_WIDTH'(sub_diff_s[WIDTH-1:0]);
                end
            end
            OP_ACC: begin
                flag = acc_sum_s[ACC_WIDTH];
                if (acc_sum_s[ACC_WIDTH] && sat) begin
                    acc_next = {ACC_WIDTH{1'b1}};
                end else begin
                    acc_next = acc_sum_s[ACC_WIDTH-1:0];
                end
                result = acc_next;
            end
            OP_CLR: begin
                acc_next = {ACC_WIDTH{1'b0}};
            end
            default: begin
                result   = {ACC_WIDTH{1'b0}};
                flag     = 1'b0;
                acc_next = acc;
            end
        endcase
    end

endmodule

// File: rtl/add_accum_unit.sv
// Two-stage valid/ready arithmetic pipeline: S1 holds operands, S2 holds the
// computed result; the accumulator commits on the edge S2 captures a beat.
module add_accum_unit
    import add_accum_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [OP_W-1:0]      in_op,
    input  logic                 in_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_result,
    output logic                 out_flag,
    output logic [ACC_WIDTH-1:0] acc_value,
    output logic [CNT_WIDTH-1:0] op_count
);

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    op_e                  op_q, op_d;
    logic                 sat_q, sat_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic                 flag_q, flag_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 s2_adv_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 retire_s;
    logic [ACC_WIDTH-1:0] alu_result_s;
    logic                 alu_flag_s;
    logic [ACC_WIDTH-1:0] alu_acc_next_s;

    add_accum_alu #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .sat      (sat_q),
        .acc      (acc_q),
        .result   (alu_result_s),
        .flag     (alu_flag_s),
        .acc_next (alu_acc_next_s)
    );

    // in_ready depends only on registers and out_ready, never on in_valid.
    always_comb begin
        s2_adv_s   = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready_s = !s1_valid_q || s2_adv_s;
        accept_s   = in_valid && in_ready_s;
        retire_s   = s2_valid_q && out_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sat_d      = sat_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            a_d        = in_a;
            b_d        = in_b;
            op_d       = op_e'(in_op);
            sat_d      = in_sat;
        end else if (s2_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // ALU reads acc_q, which already holds the previous ACC beat's update.
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        flag_d     = flag_q;
        acc_d      = acc_q;
        if (s2_adv_s) begin
            s2_valid_d = 1'b1;
            result_d   = alu_result_s;
            flag_d     = alu_flag_s;
            acc_d      = alu_acc_next_s;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    always_comb begin
        if (retire_s) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            op_q       <= OP_ADD;
            sat_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= {ACC_WIDTH{1'b0}};
            flag_q     <= 1'b0;
            acc_q      <= {ACC_WIDTH{1'b0}};
            cnt_q      <= {CNT_WIDTH{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            sat_q      <= sat_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            flag_q     <= flag_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = s2_valid_q;
    assign out_result = result_q;
    assign out_flag   = flag_q;
    assign acc_value  = acc_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_add_accum_unit.sv
// Self-checking bench for add_accum_unit with a behavioural arithmetic model.
module tb_add_accum_unit;

    localparam int W  = 4;
    localparam int AW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_sat;
    logic [W-1:0]  in_a, in_b;
    logic [1:0]    in_op;
    logic          out_valid, out_ready, out_flag;
    logic [AW-1:0] out_result, acc_value;
    logic [CW-1:0] op_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [8:0]    exp_q[$];
    logic [8:0]    obs_q[$];
    int            m_acc;
    logic [CW-1:0] exp_cnt;
    logic          s_in_ready, s_out_valid, s_out_flag;
    logic [AW-1:0] s_out_result;

    always #5 clk = ~clk;

    add_accum_unit #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_sat     (in_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flag   (out_flag),
        .acc_value  (acc_value),
        .op_count   (op_count)
    );

    // Reference: plain integer arithmetic evaluated in acceptance order.
    function automatic void model_apply(input int a, input int b, input int op, input logic sat);
        int r;
        int f;
        int s;
        r = 0;
        f = 0;
        case (op)
            0: begin
                r = a + b;
                f = (a + b >= (1 << (W + 1))) ? 1 : 0;
            end
            1: begin
                if (a >= b) begin
                    r = a - b;
                end else begin
                    f = 1;
                    r = sat ? 0 : (a - b + (1 << W));
                end
            end
            2: begin
                s = m_acc + a + b;
                if (s >= (1 << AW)) begin
                    f = 1;
                    m_acc = sat ? ((1 << AW) - 1) : (s - (1 << AW));
                end else begin
                    m_acc = s;
                end
                r = m_acc;
            end
            default: begin
                m_acc = 0;
            end
        endcase
        exp_q.push_back({f[0], r[AW-1:0]});
        exp_cnt = exp_cnt + 8'd1;
    endfunction

    task automatic step(input logic v, input int a, input int b, input int op,
                        input logic sat, input logic ordy, output logic accepted);
        @(negedge clk);
        in_valid  = v;
        in_a      = a[W-1:0];
        in_b      = b[W-1:0];
        in_op     = op[1:0];
        in_sat    = sat;
        out_ready = ordy;
        #1;
        s_in_ready   = in_ready;
        s_out_valid  = out_valid;
        s_out_result = out_result;
        s_out_flag   = out_flag;
        accepted     = v && in_ready;
        if (out_valid && ordy) obs_q.push_back({out_flag, out_result});
        if (accepted) model_apply(a, b, op, sat);
    endtask

    task automatic send(input int a, input int b, input int op, input logic sat);
        logic accepted;
        int   t;
        t = 0;
        accepted = 1'b0;
        while (!accepted && t < 50) begin
            step(1'b1, a, b, op, sat, 1'b1, accepted);
            t++;
        end
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL send_timeout: accepted %0d required 1", accepted);
        end
    endtask

    task automatic drain();
        logic accepted;
        int   t;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 40) begin
            step(1'b0, 0, 0, 0, 1'b0, 1'b1, accepted);
            t++;
        end
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, accepted);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL drain_count: got %0d results required %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        exp_q.delete();
        obs_q.delete();
        m_acc   = 0;
        exp_cnt = 8'd0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        assert_reset();
        n_checks += 5;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        if (acc_value !== 8'd0) begin n_fail++; $display("FAIL rst_acc: got %0d required 0", acc_value); end
        if (op_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", op_count); end
        if ({out_flag, out_result} !== 9'd0) begin n_fail++; $display("FAIL rst_result: got %0d required 0", {out_flag, out_result}); end
        release_reset();
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_add();
        logic accepted;
        step(1'b1, 9, 8, 0, 1'b0, 1'b1, accepted);
        n_checks++;
        if (accepted !== 1'b1) begin n_fail++; $display("FAIL add_accept: got %b required 1", accepted); end
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, accepted);
        n_checks++;
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %b required 0", s_out_valid); end
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, accepted);
        n_checks += 2;
        if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: got %b required 1", s_out_valid); end
        if ({s_out_flag, s_out_result} !== {1'b0, 8'd17}) begin
            n_fail++; $display("FAIL add_result: got flag %b result %0d required flag 0 result 17", s_out_flag, s_out_result);
        end
        drain();
        n_checks += 2;
        if (acc_value !== 8'd0) begin n_fail++; $display("FAIL add_acc: got %0d required 0", acc_value); end
        if (op_count !== 8'd1) begin n_fail++; $display("FAIL add_count: got %0d required 1", op_count); end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_sub();
        logic [8:0] req [3] = '{9'h10E, 9'h100, 9'h002};
        send(3, 5, 1, 1'b0);
        send(3, 5, 1, 1'b1);
        send(5, 3, 1, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== req[i]) begin
                n_fail++;
                $display("FAIL sub_%0d: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1FF, req[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_acc();
        logic [8:0] req;
        for (int pass = 0; pass < 2; pass++) begin
            logic sat;
            sat = (pass == 0);
            send(0, 0, 3, 1'b0);
            for (int k = 0; k < 9; k++) send(15, 15, 2, sat);
            drain();
            for (int k = 1; k < 10; k++) begin
                if (k < 9) req = {1'b0, 8'(k * 30)};
                else req = sat ? 9'h1FF : 9'h10E;
                n_checks++;
                if (k >= obs_q.size() || obs_q[k] !== req) begin
                    n_fail++;
                    $display("FAIL acc_sat%0d_beat%0d: got %h required %h", sat, k, (k < obs_q.size()) ? obs_q[k] : 9'h000, req);
                end
            end
            n_checks++;
            if (acc_value !== req[7:0]) begin n_fail++; $display("FAIL acc_final_sat%0d: got %0d required %0d", sat, acc_value, req[7:0]); end
            exp_q.delete();
            obs_q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic          accepted;
        logic [CW-1:0] base;
        logic [8:0]    req [3] = '{9'd3, 9'd7, 9'd11};
        base = exp_cnt;
        step(1'b1, 1, 2, 0, 1'b0, 1'b0, accepted);
        n_checks++;
        if (accepted !== 1'b1) begin n_fail++; $display("FAIL bp_accept1: got %b required 1", accepted); end
        step(1'b1, 3, 4, 0, 1'b0, 1'b0, accepted);
        n_checks++;
        if (accepted !== 1'b1) begin n_fail++; $display("FAIL bp_accept2: got %b required 1", accepted); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5, 6, 0, 1'b0, 1'b0, accepted);
            n_checks += 2;
            if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b required 0", i, s_in_ready); end
            if ({s_out_valid, s_out_result} !== {1'b1, 8'd3}) begin
                n_fail++; $display("FAIL bp_hold_%0d: got valid %b result %0d required valid 1 result 3", i, s_out_valid, s_out_result);
            end
        end
        step(1'b1, 5, 6, 0, 1'b0, 1'b1, accepted);
        n_checks++;
        if (s_in_ready !== 1'b1 || accepted !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got in_ready %b required 1", s_in_ready);
        end
        drain();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== req[i]) begin
                n_fail++; $display("FAIL bp_order_%0d: got %0d required %0d", i, (i < obs_q.size()) ? obs_q[i] : 9'h1FF, req[i]);
            end
        end
        n_checks++;
        if (op_count !== base + 8'd3) begin n_fail++; $display("FAIL bp_count: got %0d required %0d", op_count, base + 8'd3); end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic accepted;
        step(1'b1, 10, 10, 2, 1'b0, 1'b0, accepted);
        step(1'b1, 12, 12, 2, 1'b0, 1'b0, accepted);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, accepted);
        assert_reset();
        n_checks += 3;
        if (acc_value !== 8'd0) begin n_fail++; $display("FAIL mid_rst_acc: got %0d required 0", acc_value); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
        if (op_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d required 0", op_count); end
        release_reset();
        send(1, 2, 2, 1'b0);
        drain();
        n_checks++;
        if (obs_q.size() < 1 || obs_q[0] !== 9'd3) begin
            n_fail++; $display("FAIL mid_rst_acc_next: got %0d required 3", (obs_q.size() > 0) ? obs_q[0] : 9'h1FF);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_clr();
        send(0, 0, 3, 1'b0);
        for (int i = 0; i < 3; i++) send(15, 15, 2, 1'b0);
        send(5, 5, 2, 1'b0);
        drain();
        n_checks++;
        if (acc_value !== 8'd100) begin n_fail++; $display("FAIL clr_setup_acc: got %0d required 100", acc_value); end
        exp_q.delete();
        obs_q.delete();
        send(9, 9, 3, 1'b1);
        send(4, 4, 0, 1'b0);
        drain();
        n_checks += 3;
        if (obs_q.size() < 1 || obs_q[0] !== 9'd0) begin n_fail++; $display("FAIL clr_result: got %0d required 0", (obs_q.size() > 0) ? obs_q[0] : 9'h1FF); end
        if (obs_q.size() < 2 || obs_q[1] !== 9'd8) begin n_fail++; $display("FAIL clr_add_after: got %0d required 8", (obs_q.size() > 1) ? obs_q[1] : 9'h1FF); end
        if (acc_value !== 8'd0) begin n_fail++; $display("FAIL clr_acc: got %0d required 0", acc_value); end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random();
        logic accepted;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), accepted);
        end
        drain();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_beat_%0d: got %h required %h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1FF, exp_q[i]);
            end
        end
        n_checks += 2;
        if (acc_value !== m_acc[AW-1:0]) begin n_fail++; $display("FAIL rand_acc: got %0d required %0d", acc_value, m_acc[AW-1:0]); end
        if (op_count !== exp_cnt) begin n_fail++; $display("FAIL rand_count: got %0d required %0d", op_count, exp_cnt); end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 2'd0;
        in_sat    = 1'b0;
        out_ready = 1'b1;
        m_acc     = 0;
        exp_cnt   = 8'd0;
        test_reset();
        test_add();
        test_sub();
        test_acc();
        test_backpressure();
        test_reset_midflight();
        test_clr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_accum_unit.md
# add_accum_unit

Parametrised, pipelined arithmetic unit for the ASIC-lab tile: unsigned add, subtract, running accumulate and accumulator clear, with optional saturation. Operands enter through a valid/ready handshake, pass through a 2-stage pipeline, and leave through a valid/ready output port with an overflow/borrow flag. It sits between the tile's input pin decode and the `uo_out` output register.

## Interface
- `WIDTH`, default 4: operand width in bits, ≥2.
- `ACC_WIDTH`, default 8: result and accumulator width; must be ≥ `WIDTH`+1.
- `CNT_WIDTH`, default 8: width of the completed-operation counter.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  unit accepts a beat this cycle.
- `in_a`, `in_b`  in  `WIDTH`  unsigned operands.
- `in_op`  in  2  opcode: 0 ADD, 1 SUB, 2 ACC, 3 CLR.
- `in_sat`  in  1  1 = saturate on overflow/borrow, 0 = wrap.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `out_result`  out  `ACC_WIDTH`  result, zero-extended.
- `out_flag`  out  1  overflow (ADD/ACC) or borrow (SUB) for this result.
- `acc_value`  out  `ACC_WIDTH`  current accumulator register.
- `op_count`  out  `CNT_WIDTH`  number of results accepted by the consumer; wraps.

## Operation
- Stage 1 (S1) registers `a`, `b`, `op`, `sat` and `s1_valid`.
- Stage 2 (S2) registers the computed result, flag and `s2_valid`. The accumulator updates on the same edge S2 captures an ACC or CLR beat.
- Arithmetic, all unsigned:
  - ADD: `a+b` in `WIDTH`+1 bits, zero-extended. Flag = carry out of bit `WIDTH`. `sat` has no effect because the sum always fits.
  - SUB: if `a≥b`, result = `a−b`, flag 0. If `a<b`, flag 1 and result = `(a−b) mod 2^WIDTH` when `sat`=0, or 0 when `sat`=1.
  - ACC: sum = `acc + a + b` in `ACC_WIDTH`+1 bits.
    - No overflow: acc ← sum, flag 0.
    - Overflow: flag 1, and acc ← `sum mod 2^ACC_WIDTH` when `sat`=0, or `2^ACC_WIDTH−1` when `sat`=1.
    - Result = new acc.
  - CLR: acc ← 0, result 0, flag 0. Operands are ignored.
- ADD and SUB never modify acc.
- Back-to-back ACC beats carry no hazard: each beat reads acc in S1→S2 transfer after the previous beat's update.
- `op_count` increments on each `out_valid && out_ready` cycle. It wraps from `2^CNT_WIDTH−1` to 0.
- An illegal combination cannot occur; all 4 opcodes are defined.

## Timing
- Reset: `s1_valid`, `s2_valid`, acc, `op_count`, `out_result` and `out_flag` all 0. Hence `out_valid`=0 and `acc_value`=0. `in_ready`=1 during and immediately after reset.
- Reset asserted mid-operation discards in-flight beats. No partial accumulator update survives.
- `s2_adv` = `s1_valid && (!s2_valid || out_ready)`.
- `in_ready` = `!s1_valid || s2_adv`. It is combinational from registers and `out_ready` only, never from `in_valid`.
- Accept = `in_valid && in_ready`.
- Latency: a beat accepted at edge N is presented at edge N+1 (S1) and with `out_valid`=1 after edge N+2.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Backpressure: with `out_ready`=0, S2 holds and `out_result`/`out_flag` stay stable. S1 fills, then `in_ready` drops. No beat is lost or duplicated.
- On the cycle `out_ready` returns, S2 and S1 both advance, and `in_ready`=1 on that same cycle.
- `in_valid` may drop without a handshake. Stage-1 contents are undefined when `s1_valid`=0.

## Structure
- Package `add_accum_pkg`: opcode enum `op_e` (OP_ADD, OP_SUB, OP_ACC, OP_CLR) and 2-bit opcode width constant.
- Sub-module `add_accum_alu`: purely combinational. Inputs: a, b, op, sat, acc. Outputs: result, flag, acc_next.
- Top holds the pipeline registers, handshake logic, accumulator and counter.

## Test plan
All scenarios use WIDTH=4, ACC_WIDTH=8.
- Reset then ADD a=9, b=8, out_ready=1 → out_valid two cycles after accept; result 17, flag 0; acc_value 0; op_count 1.
- SUB a=3, b=5 with sat=0 → result 14, flag 1. Repeat with sat=1 → result 0, flag 1. SUB a=5, b=3 → result 2, flag 0.
- Back-to-back ACC a=15, b=15, sat=1, nine beats, out_ready=1 → results 30, 60, …, 240, then 255 with flag 1. Repeat from CLR with sat=0 → 9th result 14, flag 1.
- Hold out_ready=0 and drive 3 valid beats → in_ready low after 2 accepts; out_result stable. Release out_ready → all 3 results in order, no drops; op_count +3.
- Assert reset while S1 and S2 hold ACC beats → acc_value 0, out_valid 0, op_count 0; the next ACC a=1, b=2 gives result 3.
- CLR after acc=100 → result 0, flag 0, acc_value 0. A following ADD 4+4 gives 8 and leaves acc 0.
